tug_playfield: RTL and testbench

//  Drives the tug-of-war light bar and feeds the round-winner detector.
//  - Conditions the raw L/R player keys (synchroniser + rising-edge detect) into one-cycle press pulses.
//  - Moves a single lit position left or right on those presses.
//  - Exports the edge lights and press pulses to the victory logic.
//  - Re-centres the light when victory logic pulses the round-restart input.

---
 rtl/tug_playfield.sv | 103 ++++++++++
 tb/tb_tug_playfield.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/tug_playfield.sv
// Tug-of-war light bar: conditions the two player keys into one-cycle press
// pulses and moves a single lit position toward the pressing player's edge.
module tug_playfield #(
    parameter int N_LIGHTS    = 9,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                L,
    input  logic                R,
    input  logic                midreset,
    output logic [N_LIGHTS-1:0] leds,
    output logic                edge_l,
    output logic                edge_r,
    output logic                l_press,
    output logic                r_press,
    output logic                locked
);

    localparam int            PW   = $clog2(N_LIGHTS);
    localparam logic [PW-1:0] CTR  = PW'((N_LIGHTS - 1) / 2);
    localparam logic [PW-1:0] MAXP = PW'(N_LIGHTS - 1);

    typedef enum logic {
        PLAY,
        LOCK
    } state_t;

    logic [SYNC_STAGES-1:0] r_l_sync;
    logic [SYNC_STAGES-1:0] r_r_sync;
    logic                   r_l_hist;
    logic                   r_r_hist;
    logic                   r_l_press;
    logic                   r_r_press;
    logic                   w_l_rise;
    logic                   w_r_rise;

    logic [PW-1:0]          r_pos;
    state_t                 r_state;
    logic                   r_locked;

    // Synchronisers and history flops come out of reset at 1, so a key that
    // is held through reset looks already pressed and yields no pulse.
    // NOTE: sequential state uses non-blocking assignments only; blocking
    // here would let later flops see this cycle's new value and collapse the chain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_l_sync  <= '1;
            r_r_sync  <= '1;
            r_l_hist  <= 1'b1;
            r_r_hist  <= 1'b1;
            r_l_press <= 1'b0;
            r_r_press <= 1'b0;
        end else begin
            r_l_sync  <= {r_l_sync[SYNC_STAGES-2:0], L};
            r_r_sync  <= {r_r_sync[SYNC_STAGES-2:0], R};
            r_l_hist  <= r_l_sync[SYNC_STAGES-1];
            r_r_hist  <= r_r_sync[SYNC_STAGES-1];
            r_l_press <= w_l_rise;
            r_r_press <= w_r_rise;
        end
    end

    assign w_l_rise = r_l_sync[SYNC_STAGES-1] & ~r_l_hist;
    assign w_r_rise = r_r_sync[SYNC_STAGES-1] & ~r_r_hist;

    // midreset outranks everything, including a press sampled on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pos    <= CTR;
            r_state  <= PLAY;
            r_locked <= 1'b0;
        end else if (midreset) begin
            r_pos    <= CTR;
            r_state  <= PLAY;
            r_locked <= 1'b0;
        end else if (r_state == PLAY) begin
            if (r_l_press && !r_r_press) begin
                if (r_pos == MAXP) begin
                    r_state  <= LOCK;
                    r_locked <= 1'b1;
                end else begin
                    r_pos <= r_pos + PW'(1);
                end
            end else if (r_r_press && !r_l_press) begin
                if (r_pos == '0) begin
                    r_state  <= LOCK;
                    r_locked <= 1'b1;
                end else begin
                    r_pos <= r_pos - PW'(1);
                end
            end
        end
    end

    assign leds    = {{(N_LIGHTS-1){1'b0}}, 1'b1} << r_pos;
    assign edge_l  = leds[N_LIGHTS-1];
    assign edge_r  = leds[0];
    assign l_press = r_l_press;
    assign r_press = r_r_press;
    assign locked  = r_locked;

endmodule

// File: tb/tb_tug_playfield.sv
// Bench for tug_playfield: directed scenarios plus random key traffic, checked
// cycle by cycle against a sample-history reference model through a scoreboard.
module tb_tug_playfield;

    localparam int N   = 9;
    localparam int S   = 2;
    localparam int CTR = (N - 1) / 2;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         L = 1'b0;
    logic         R = 1'b0;
    logic         midreset = 1'b0;
    logic [N-1:0] leds;
    logic         edge_l, edge_r, l_press, r_press, locked;

    tug_playfield #(.N_LIGHTS(N), .SYNC_STAGES(S)) dut (
        .clk      (clk),
        .reset    (reset),
        .L        (L),
        .R        (R),
        .midreset (midreset),
        .leds     (leds),
        .edge_l   (edge_l),
        .edge_r   (edge_r),
        .l_press  (l_press),
        .r_press  (r_press),
        .locked   (locked)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] leds;
        logic         lp;
        logic         rp;
        logic         lock;
        logic         el;
        logic         er;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model: key samples taken at each edge, current position and lock.
    int   lq[$];
    int   rq[$];
    int   m_pos;
    bit   m_lock;
    bit   m_lp;
    bit   m_rp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        lq.delete();
        rq.delete();
        for (int i = 0; i < S + 1; i++) begin
            lq.push_back(1);
            rq.push_back(1);
        end
        m_pos  = CTR;
        m_lock = 1'b0;
        m_lp   = 1'b0;
        m_rp   = 1'b0;
    endtask

    // Apply inputs for the coming edge and queue the outputs expected after it.
    task automatic drive(input bit l, input bit r, input bit m);
        exp_t e;
        L        = l;
        R        = r;
        midreset = m;
        if (m) begin
            m_pos  = CTR;
            m_lock = 1'b0;
        end else if (!m_lock) begin
            if (m_lp && !m_rp) begin
                if (m_pos == N - 1) m_lock = 1'b1;
                else m_pos = m_pos + 1;
            end else if (m_rp && !m_lp) begin
                if (m_pos == 0) m_lock = 1'b1;
                else m_pos = m_pos - 1;
            end
        end
        lq.push_back(int'(l));
        rq.push_back(int'(r));
        if (lq.size() > S + 2) void'(lq.pop_front());
        if (rq.size() > S + 2) void'(rq.pop_front());
        // A pulse after edge t means the key was seen high at t-S and low at t-S-1.
        m_lp   = (lq[1] == 1) && (lq[0] == 0);
        m_rp   = (rq[1] == 1) && (rq[0] == 0);
        e.leds = N'(1) << m_pos;
        e.lp   = m_lp;
        e.rp   = m_rp;
        e.lock = m_lock;
        e.el   = (m_pos == N - 1);
        e.er   = (m_pos == 0);
        sb.push_back(e);
    endtask

    task automatic step(input bit l, input bit r, input bit m);
        @(negedge clk);
        drive(l, r, m);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic press_l();
        step(1'b1, 1'b0, 1'b0);
        idle(4);
    endtask

    task automatic press_r();
        step(1'b0, 1'b1, 1'b0);
        idle(4);
    endtask

    // Monitor: every cycle out of reset the DUT presents a full output set.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (reset && sb.size() > 0) begin
            e = sb.pop_front();
            check("leds",    32'(leds),    32'(e.leds));
            check("l_press", 32'(l_press), 32'(e.lp));
            check("r_press", 32'(r_press), 32'(e.rp));
            check("locked",  32'(locked),  32'(e.lock));
            check("edge_l",  32'(edge_l),  32'(e.el));
            check("edge_r",  32'(edge_r),  32'(e.er));
        end
    end

    initial begin
        int wait_cycles;

        // Scenario 1: key held through reset produces no press.
        model_reset();
        L = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_leds",   32'(leds),    32'h010);
        check("rst_locked", 32'(locked),  32'h0);
        check("rst_lpress", 32'(l_press), 32'h0);
        reset = 1'b1;
        drive(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 1'b0);
        check("held_leds", 32'(leds), 32'h010);
        idle(3);

        // Scenario 2: four left presses walk the light to the left edge.
        for (int i = 0; i < 4; i++) press_l();
        check("left4_leds",   32'(leds),   32'h100);
        check("left4_edge_l", 32'(edge_l), 32'h1);

        // Scenario 3: winning press locks; right press in lock only pulses.
        press_l();
        check("win_l_leds",   32'(leds),   32'h100);
        check("win_l_locked", 32'(locked), 32'h1);
        press_r();
        check("lock_r_leds", 32'(leds), 32'h100);

        // Scenario 4: midreset re-centres; a coincident press is discarded.
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        check("mid_leds",   32'(leds),   32'h010);
        check("mid_locked", 32'(locked), 32'h0);
        step(1'b0, 1'b1, 1'b0);
        idle(2);
        step(1'b0, 1'b0, 1'b1);
        idle(2);
        check("mid_coinc_leds", 32'(leds), 32'h010);

        // Scenario 5: simultaneous presses cancel; right side wins after five.
        step(1'b1, 1'b1, 1'b0);
        idle(4);
        check("both_leds", 32'(leds), 32'h010);
        for (int i = 0; i < 5; i++) press_r();
        check("win_r_leds",   32'(leds),   32'h001);
        check("win_r_locked", 32'(locked), 32'h1);

        // Scenario 6: async reset from LOCK at the left edge.
        step(1'b0, 1'b0, 1'b1);
        idle(1);
        for (int i = 0; i < 5; i++) press_l();
        check("pre_rst_locked", 32'(locked), 32'h1);
        #2;
        sb.delete();
        reset = 1'b0;
        #1;
        check("async_leds",   32'(leds),   32'h010);
        check("async_locked", 32'(locked), 32'h0);
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0);

        // Random key traffic with occasional round restarts.
        for (int i = 0; i < 1500; i++) begin
            step(($urandom % 4) == 0, ($urandom % 4) == 0, ($urandom % 50) == 0);
        end
        idle(4);

        wait_cycles = 0;
        while (sb.size() > 0 && wait_cycles < 10) begin
            @(negedge clk);
            wait_cycles++;
        end
        check("scoreboard_drained", 32'(sb.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
